// File: rtl/zbt_pkg.sv
// Shared types and constants for the ZBT APB loader.
package zbt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSetup,
    StAccess,
    StDone
  } state_e;

  localparam logic       MODE_LOAD   = 1'b0;
  localparam logic       MODE_VERIFY = 1'b1;
  localparam logic [3:0] PSTRB_ALL   = 4'hF;

endpackage

// File: rtl/zbt_apb_loader_if.sv
// APB bus between the loader (master) and the SRAM controller's low-priority port (slave).
interface zbt_apb_loader_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/zbt_skid_buf.sv
// One-entry valid/ready holding register; accepts a new word in the cycle the old one drains.
module zbt_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic        valid_q;
  logic [31:0] data_q;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 32'h0;
    end else if (in_valid && in_ready) begin
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/zbt_apb_loader.sv
// APB master that writes a word stream into ZBT SRAM (LOAD) or reads and compares it (VERIFY).
module zbt_apb_loader
  import zbt_pkg::*;
#(
  parameter int unsigned AW    = 23,
  parameter int unsigned CNT_W = 21
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  zbt_apb_loader_if.master apb,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             slverr,
  output logic             mismatch,
  output logic [AW-1:0]    first_bad
);

  state_e           state_q, state_d;
  logic             mode_q;
  logic             abort_q;
  logic             aborted_q, slverr_q, mismatch_q;
  logic [AW-1:0]    addr_q, first_bad_q;
  logic [CNT_W-1:0] remaining_q;

  logic        buf_valid, buf_in_ready, buf_in_valid;
  logic [31:0] buf_data;
  logic        start_ok, xfer_done, last_word, abort_hit, fetch_ok, s_fire;

  assign start_ok  = (state_q == StIdle) && start;
  assign xfer_done = (state_q == StAccess) && apb.PREADY;
  assign last_word = (remaining_q == CNT_W'(1));
  assign abort_hit = abort_q | abort;

  // Never pull a word the job will not use: stop after the last one or once abort is seen.
  assign fetch_ok = ((state_q == StFetch) && !abort) ||
                    ((state_q == StAccess) && !last_word && !abort_hit);

  assign buf_in_valid = s_valid & fetch_ok;
  assign s_ready      = fetch_ok & buf_in_ready;
  assign s_fire       = s_valid & s_ready;

  zbt_skid_buf u_skid_buf (
    .clk       (HCLK),
    .rst       (HRESET),
    .flush     (state_q == StDone),
    .in_valid  (buf_in_valid),
    .in_data   (s_data),
    .in_ready  (buf_in_ready),
    .out_valid (buf_valid),
    .out_ready (xfer_done),
    .out_data  (buf_data)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (word_count == '0) ? StDone : StFetch;
      end
      StFetch: begin
        if (abort)                  state_d = StDone;
        else if (buf_valid || s_fire) state_d = StSetup;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (apb.PREADY) begin
          if (last_word || abort_hit) state_d = StDone;
          else if (s_fire)            state_d = StSetup;
          else                        state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    apb.PADDR   = 32'h0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PSTRB   = 4'h0;
    apb.PWDATA  = 32'h0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StSetup, StAccess: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state_q == StAccess);
        apb.PADDR   = 32'(addr_q);
        apb.PWRITE  = ~mode_q;
        apb.PSTRB   = (mode_q == MODE_LOAD) ? PSTRB_ALL : 4'h0;
        apb.PWDATA  = buf_data;
        busy        = 1'b1;
      end
      StFetch: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mode_q      <= MODE_LOAD;
      addr_q      <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
      aborted_q   <= 1'b0;
      slverr_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else if (start_ok) begin
      mode_q      <= mode;
      addr_q      <= {base_addr[AW-1:2], 2'b00};
      remaining_q <= word_count;
      abort_q     <= 1'b0;
      aborted_q   <= 1'b0;
      slverr_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else begin
      if (((state_q == StSetup) || (state_q == StAccess)) && abort) abort_q <= 1'b1;
      if ((state_q == StFetch) && abort) aborted_q <= 1'b1;
      if (xfer_done) begin
        if (apb.PSLVERR) slverr_q <= 1'b1;
        if ((mode_q == MODE_VERIFY) && (apb.PRDATA != buf_data) && !mismatch_q) begin
          mismatch_q  <= 1'b1;
          first_bad_q <= addr_q;
        end
        addr_q      <= addr_q + AW'(4);
        remaining_q <= remaining_q - CNT_W'(1);
        if (abort_hit && !last_word) aborted_q <= 1'b1;
      end
    end
  end

  assign aborted   = aborted_q;
  assign slverr    = slverr_q;
  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;

endmodule

// File: tb/tb_zbt_apb_loader.sv
// Directed bench for zbt_apb_loader: LOAD, stalls, VERIFY, address wrap, abort, reset.
module tb_zbt_apb_loader;
  import zbt_pkg::*;

  localparam int unsigned AW    = 23;
  localparam int unsigned CNT_W = 21;

  logic             HCLK;
  logic             HRESET;
  logic             start, mode, abort, s_valid, s_ready;
  logic [AW-1:0]    base_addr;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      s_data;
  logic             busy, done, aborted, slverr, mismatch;
  logic [AW-1:0]    first_bad;

  zbt_apb_loader_if apb ();

  logic [31:0] mem [256];
  assign apb.PRDATA = mem[apb.PADDR[9:2]];

  zbt_apb_loader #(.AW(AW), .CNT_W(CNT_W)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .apb        (apb),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .slverr     (slverr),
    .mismatch   (mismatch),
    .first_bad  (first_bad)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int          total, bad;
  logic [31:0] src_tab [16];
  int          src_idx, src_len;
  bit          src_en;
  int          n_cpl, n_psel, n_stall, stall_at, stall_left, abort_at;
  bit          stall_chk;
  logic [31:0] exp_stall_addr, exp_stall_data;
  logic [31:0] log_addr [16];
  logic [31:0] log_data [16];
  logic        log_wr   [16];
  logic [3:0]  log_strb [16];
  int          steps;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    n_cpl = 0; n_psel = 0; n_stall = 0;
  endtask

  task automatic drive_src();
    s_valid = src_en && (src_idx < src_len);
    s_data  = (src_idx < 16) ? src_tab[src_idx] : 32'h0;
  endtask

  // Sample the settled pre-edge values, clock once, then update stream/slave drivers.
  task automatic step();
    bit fire, cpl;
    fire = s_valid && s_ready;
    cpl  = apb.PSEL && apb.PENABLE && apb.PREADY;
    if (cpl && n_cpl < 16) begin
      log_addr[n_cpl] = apb.PADDR;
      log_data[n_cpl] = apb.PWDATA;
      log_wr[n_cpl]   = apb.PWRITE;
      log_strb[n_cpl] = apb.PSTRB;
    end
    if (cpl) n_cpl++;
    if (apb.PSEL) n_psel++;
    @(posedge HCLK);
    #1;
    if (fire) src_idx++;
    drive_src();
    if (apb.PSEL && apb.PENABLE && n_cpl == stall_at && stall_left > 0) begin
      apb.PREADY = 1'b0;
      stall_left--;
    end else begin
      apb.PREADY = 1'b1;
    end
    if (abort_at >= 0) abort = apb.PSEL && apb.PENABLE && (n_cpl == abort_at);
    #1;
    if (stall_chk && apb.PSEL && apb.PENABLE && !apb.PREADY) begin
      n_stall++;
      chk("stall_paddr", apb.PADDR, exp_stall_addr);
      chk("stall_pwdata", apb.PWDATA, exp_stall_data);
      chk("stall_s_ready", s_ready, 0);
    end
  endtask

  task automatic set_src(input logic [31:0] first, input int len);
    for (int i = 0; i < 16; i++) src_tab[i] = first + 32'(i);
    src_len = len; src_idx = 0; src_en = 1'b1;
    drive_src();
  endtask

  task automatic kick(input logic m, input logic [AW-1:0] b, input logic [CNT_W-1:0] n);
    clear_logs();
    start = 1'b1; mode = m; base_addr = b; word_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max);
    steps = 0;
    while (done !== 1'b1 && steps < max) begin
      step();
      steps++;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    HRESET = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    base_addr = '0; word_count = '0; s_valid = 1'b0; s_data = 32'h0;
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;
    src_en = 1'b0; src_len = 0; src_idx = 0;
    stall_at = -1; stall_left = 0; abort_at = -1; stall_chk = 1'b0;
    exp_stall_addr = 32'h0; exp_stall_data = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    clear_logs();
    step(); step(); step();

    // Reset state
    chk("rst_psel", apb.PSEL, 0);
    chk("rst_penable", apb.PENABLE, 0);
    chk("rst_paddr", apb.PADDR, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_flags", {aborted, slverr, mismatch}, 0);
    chk("rst_first_bad", first_bad, 0);
    HRESET = 1'b0;
    step();

    // 1: plain LOAD of four words
    set_src(32'hA0, 4);
    chk("t1_idle_s_ready", s_ready, 0);
    kick(MODE_LOAD, 23'h100, 4);
    chk("t1_busy", busy, 1);
    run_until_done(40);
    chk("t1_done", done, 1);
    chk("t1_steps", steps, 9);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_ncpl", n_cpl, 4);
    chk("t1_npsel", n_psel, 8);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[i], 32'h100 + 32'(4 * i));
      chk("t1_data", log_data[i], 32'hA0 + 32'(i));
      chk("t1_wr_strb", {log_wr[i], log_strb[i]}, 5'h1F);
    end
    chk("t1_consumed", src_idx, 4);
    step();
    chk("t1_done_pulse", {done, busy}, 0);

    // 2: three-cycle PREADY stall on the second access
    set_src(32'hD0, 4);
    stall_at = 1; stall_left = 3; stall_chk = 1'b1;
    exp_stall_addr = 32'h104; exp_stall_data = 32'hD1;
    kick(MODE_LOAD, 23'h100, 4);
    run_until_done(40);
    stall_chk = 1'b0; stall_at = -1;
    chk("t2_done", done, 1);
    chk("t2_steps", steps, 12);
    chk("t2_nstall", n_stall, 3);
    chk("t2_npsel", n_psel, 11);
    for (int i = 0; i < 4; i++) chk("t2_data", log_data[i], 32'hD0 + 32'(i));
    step();

    // 3: VERIFY with a bad third word
    mem[8'h80] = 32'h11; mem[8'h81] = 32'h22; mem[8'h82] = 32'h99;
    set_src(32'h0, 3);
    src_tab[0] = 32'h11; src_tab[1] = 32'h22; src_tab[2] = 32'h33;
    drive_src();
    kick(MODE_VERIFY, 23'h200, 3);
    run_until_done(40);
    chk("t3_done", done, 1);
    chk("t3_steps", steps, 7);
    chk("t3_wr_strb", {log_wr[0], log_strb[0]}, 5'h00);
    step();
    chk("t3_mismatch", mismatch, 1);
    chk("t3_first_bad", first_bad, 23'h208);
    chk("t3_other_flags", {aborted, slverr}, 0);

    // 4: address wrap, unaligned base, PSLVERR; sticky flags cleared by start
    apb.PSLVERR = 1'b1;
    set_src(32'hB0, 4);
    kick(MODE_LOAD, 23'h7FFFFB, 4);
    run_until_done(40);
    apb.PSLVERR = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_addr0", log_addr[0], 32'h7FFFF8);
    chk("t4_addr1", log_addr[1], 32'h7FFFFC);
    chk("t4_addr2", log_addr[2], 32'h0);
    chk("t4_addr3", log_addr[3], 32'h4);
    chk("t4_slverr", slverr, 1);
    chk("t4_mismatch_cleared", {mismatch, 23'(first_bad)}, 0);
    step();

    // 5: abort during the second ACCESS of a ten-word job
    set_src(32'hC0, 10);
    abort_at = 1;
    kick(MODE_LOAD, 23'h300, 10);
    run_until_done(40);
    abort_at = -1; abort = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_steps", steps, 5);
    chk("t5_ncpl", n_cpl, 2);
    chk("t5_npsel", n_psel, 4);
    chk("t5_addr1", log_addr[1], 32'h304);
    chk("t5_aborted", aborted, 1);
    chk("t5_consumed", src_idx, 2);
    step();

    // 5b: abort while waiting in FETCH with no stream data
    src_en = 1'b0; src_len = 0; src_idx = 0; drive_src();
    kick(MODE_LOAD, 23'h400, 2);
    step(); step();
    chk("t5b_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5b_done", done, 1);
    chk("t5b_aborted", aborted, 1);
    chk("t5b_npsel", n_psel, 0);
    step();

    // 6: zero-length job with simultaneous abort
    clear_logs();
    start = 1'b1; abort = 1'b1; mode = MODE_LOAD; base_addr = 23'h10; word_count = '0;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t6_done", {done, busy}, 2'b10);
    chk("t6_aborted", aborted, 0);
    chk("t6_npsel", n_psel, 0);
    step();
    chk("t6_done_pulse", done, 0);

    // 6b: HRESET while stalled in ACCESS
    set_src(32'hE0, 3);
    stall_at = 0; stall_left = 20;
    kick(MODE_LOAD, 23'h500, 3);
    steps = 0;
    while (!(apb.PSEL && apb.PENABLE) && steps < 10) begin
      step();
      steps++;
    end
    chk("t6b_in_access", {apb.PSEL, apb.PENABLE}, 2'b11);
    HRESET = 1'b1;
    step();
    chk("t6b_psel", {apb.PSEL, apb.PENABLE}, 0);
    chk("t6b_busy", busy, 0);
    chk("t6b_ncpl", n_cpl, 0);
    HRESET = 1'b0; stall_at = -1; stall_left = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
